cpu_bus_cycle_ctrl: RTL and testbench
=====================================

# cpu_bus_cycle_ctrl

Parametrised Z80-style machine-cycle sequencer between the CPU control unit and the external bus. It runs one bus transaction per request: opcode fetch (M1 with refresh), memory read, memory write, I/O read, I/O write, or interrupt acknowledge. The bus strobes follow T-state sequencing, with configurable mandatory wait states and an external wait input. It replaces the hard-wired strobe generation in the control unit, and the control unit sees a simple valid/ready request/response port.

## Interface
- ADDR_W, 16, address bus width
- DATA_W, 8, data bus width
- MEM_WAIT, 0, mandatory TW states for fetch/memory cycles (0..15)
- IO_WAIT, 1, mandatory TW states for I/O cycles; interrupt acknowledge uses IO_WAIT+1 (max 14)

Ports:
- clk  in  1  single clock, one period = one T-state
- reset  in  1  synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  request accepted on the edge where valid&ready
- req_type  in  3  0 fetch, 1 mem rd, 2 mem wr, 3 io rd, 4 io wr, 5 int ack, 6/7 reserved
- req_addr  in  ADDR_W  transaction address
- req_wdata  in  DATA_W  write data
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  DATA_W  captured read data; held until next capture
- rfsh_addr  in  ADDR_W  refresh address driven in fetch T3/T4
- wait_in  in  1  active-high wait request from memory/I/O
- address_bus  out  ADDR_W
- data_in  in  DATA_W
- data_out  out  DATA_W
- data_oe  out  1  data_out drive enable
- m1, mreq, iorq, rd, wr, rfsh  out  1 each, active-high strobes

## Operation
- States: IDLE, T1, T2, TW, T3, T4. T4 is used only by fetch.
- Capture on acceptance: type, addr, wdata. Load the 4-bit wait counter with W = MEM_WAIT (types 0–2), IO_WAIT (3, 4) or IO_WAIT+1 (5).
- Reserved types: accepted and dropped. No strobes, no rsp_valid, state stays IDLE.
- Exit rule for T2 and TW:
  - if cnt≠0: go to TW, cnt−1;
  - else if wait_in=1: go to TW;
  - else go to T3.
- The result is exactly W TW cycles, plus one more per cycle that wait_in is sampled high after the counter is exhausted.
- Fetch:
  - T1/T2/TW: m1=mreq=rd=1, address_bus=addr.
  - data_in is captured on the edge leaving T2/TW.
  - T3/T4: m1=rd=0, mreq=rfsh=1, address_bus=rfsh_addr.
- Mem rd: mreq=rd=1 in T1..T3. data_in is captured on the edge leaving T3.
- Mem wr: mreq=1 in T1..T3, wr=1 in T2..T3. data_oe=1 in T1..T3.
- IO rd/wr: address valid T1..T3. iorq and rd (or wr) are 1 in T2..T3. For io wr, data_oe=1 in T1..T3.
- Int ack: m1=1 in T1..T3, iorq=1 in TW (last) and T3, rd=0. The vector is captured on the edge leaving T3.
- rsp_valid = 1 for exactly the cycle after the capture edge:
  - fetch: during T3;
  - other types: cycle after T3, for writes too.
- Outside active cycles: address_bus holds its last value, data_out=req_wdata of the last write, all strobes 0.

## Timing
- Reset values: state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, address_bus=0, data_out=0, data_oe=0, all strobes 0.
- Reset asserted mid-transaction: on the next edge, all outputs take reset values. No rsp_valid is generated for the aborted cycle.
- req_ready=1 in IDLE, in the final T3 of non-fetch types, and in fetch T4.
- Acceptance in a final state goes directly to T1 with no idle cycle (back-to-back). rsp_valid of the finishing cycle then coincides with the new T1.
- Latency from acceptance edge, W=0 and wait_in=0:
  - fetch rsp_valid in the 3rd cycle (T3); transaction occupies 4 cycles.
  - mem rd/wr rsp_valid in the 4th cycle.
  - io rd/wr (IO_WAIT=1) in the 5th cycle.
- wait_in is ignored in T1, T3, T4 and IDLE.
- Sequencing is identical for every ADDR_W/DATA_W.

## Test plan
- Fetch, MEM_WAIT=0, addr=0x1234, rfsh_addr=0x0042, data_in=0x3E at end of T2 -> m1/mreq/rd high 2 cycles, then rfsh 2 cycles on 0x0042; rsp_rdata=0x3E with rsp_valid in T3.
- Mem wr addr=0x8000 wdata=0xA5, wait_in high for 2 cycles from T2 -> 2 TW cycles; wr high T2..T3; data_oe 5 cycles; rsp_valid once.
- IO rd addr=0x00FE, IO_WAIT=1, data_in=0x7F -> iorq/rd high T2, TW, T3; rsp_rdata=0x7F 5 cycles after accept.
- Int ack, IO_WAIT=1, data_in=0xFF -> 2 TW cycles; iorq only in last TW+T3; m1 T1..T3; rsp_rdata=0xFF.
- Back-to-back fetch then mem rd with req_valid held -> new T1 directly follows fetch T4; no idle cycle.
- Reset during TW of a mem rd; reserved type 6 -> strobes 0 next cycle, no rsp_valid; type 6 accepted with no bus activity and no response.

Source files
------------

// File: rtl/cpu_bus_cycle_ctrl.sv
// cpu_bus_cycle_ctrl: Z80-style machine-cycle sequencer turning valid/ready requests into T-state bus strobes.
module cpu_bus_cycle_ctrl #(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 8,
    parameter int MEM_WAIT = 0,
    parameter int IO_WAIT  = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_type,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    input  logic [ADDR_W-1:0] rfsh_addr,
    input  logic              wait_in,
    output logic [ADDR_W-1:0] address_bus,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              data_oe,
    output logic              m1,
    output logic              mreq,
    output logic              iorq,
    output logic              rd,
    output logic              wr,
    output logic              rfsh
);
    typedef enum logic [2:0] {IDLE, T1, T2, TW, T3, T4} state_t;

    state_t            state_q, state_d;
    logic [2:0]        type_q, type_d;
    logic [ADDR_W-1:0] addr_q, addr_d, abus_q;
    logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              rsp_q, rsp_d;
    logic              accept, active, fetch, early, body, late, is_wr;

    function automatic logic [3:0] wait_of(input logic [2:0] t);
        return t <= 3'd2 ? 4'(MEM_WAIT) : t == 3'd5 ? 4'(IO_WAIT + 1) : 4'(IO_WAIT);
    endfunction

    assign fetch     = type_q == 3'd0;
    assign is_wr     = type_q == 3'd2 || type_q == 3'd4;
    assign active    = state_q != IDLE;
    assign early     = state_q == T1 || state_q == T2 || state_q == TW;
    assign body      = early || state_q == T3;
    assign late      = state_q == T2 || state_q == TW || state_q == T3;
    assign req_ready = state_q == IDLE || state_q == T4 || (state_q == T3 && !fetch);
    // Reserved types handshake normally but never leave IDLE.
    assign accept    = req_valid && req_ready && req_type <= 3'd5;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        type_d  = type_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        rsp_d   = 1'b0;
        case (state_q)
            T1: state_d = T2;
            T2, TW: begin
                state_d = (cnt_q != 4'd0 || wait_in) ? TW : T3;
                cnt_d   = cnt_q != 4'd0 ? cnt_q - 4'd1 : cnt_q;
                if (fetch && state_d == T3) begin
                    rdata_d = data_in;
                    rsp_d   = 1'b1;
                end
            end
            T3: begin
                state_d = fetch ? T4 : IDLE;
                rsp_d   = !fetch;
                // Odd types (mem rd, io rd, int ack) are the non-fetch reads.
                if (!fetch && type_q[0]) rdata_d = data_in;
            end
            T4: state_d = IDLE;
            default: ;
        endcase
        if (accept) begin
            state_d = T1;
            type_d  = req_type;
            addr_d  = req_addr;
            cnt_d   = wait_of(req_type);
            if (req_type == 3'd2 || req_type == 3'd4) wdata_d = req_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            type_q  <= 3'd0;
            addr_q  <= '0;
            abus_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            cnt_q   <= 4'd0;
            rsp_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            type_q  <= type_d;
            addr_q  <= addr_d;
            abus_q  <= address_bus;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
            rsp_q   <= rsp_d;
        end
    end

    assign m1   = (fetch && early) || (type_q == 3'd5 && body);
    assign mreq = (fetch && active) || ((type_q == 3'd1 || type_q == 3'd2) && body);
    // Int ack raises iorq once the mandatory waits are spent, so it spans the last TW and T3.
    assign iorq = ((type_q == 3'd3 || type_q == 3'd4) && late)
                || (type_q == 3'd5 && (state_q == T3 || (state_q == TW && cnt_q == 4'd0)));
    assign rd   = (fetch && early) || (type_q == 3'd1 && body) || (type_q == 3'd3 && late);
    assign wr   = is_wr && late;
    assign rfsh = fetch && (state_q == T3 || state_q == T4);
    assign data_oe     = is_wr && body;
    assign address_bus = !active ? abus_q : rfsh ? rfsh_addr : addr_q;
    assign data_out    = wdata_q;
    assign rsp_valid   = rsp_q;
    assign rsp_rdata   = rdata_q;
endmodule

// File: tb/tb_cpu_bus_cycle_ctrl.sv
// tb_cpu_bus_cycle_ctrl: directed bus-cycle vectors with a response scoreboard checked by a separate monitor.
module tb_cpu_bus_cycle_ctrl;
    logic clk = 1'b0, reset = 1'b1, req_valid = 1'b0, wait_in = 1'b0;
    logic [2:0] req_type = 3'd0;
    logic [15:0] req_addr = '0, rfsh_addr = 16'h0042;
    logic [7:0] req_wdata = '0, data_in = '0;
    logic req_ready, rsp_valid, data_oe, m1, mreq, iorq, rd, wr, rfsh;
    logic [7:0] rsp_rdata, data_out, sv;
    logic [15:0] address_bus;

    cpu_bus_cycle_ctrl #(.ADDR_W(16), .DATA_W(8), .MEM_WAIT(0), .IO_WAIT(1)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_type(req_type), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rfsh_addr(rfsh_addr),
        .wait_in(wait_in), .address_bus(address_bus), .data_in(data_in),
        .data_out(data_out), .data_oe(data_oe), .m1(m1), .mreq(mreq),
        .iorq(iorq), .rd(rd), .wr(wr), .rfsh(rfsh)
    );

    always #5 clk = ~clk;

    // {ready, m1, mreq, iorq, rd, wr, rfsh, oe}
    assign sv = {req_ready, m1, mreq, iorq, rd, wr, rfsh, data_oe};

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0, bad = 0;
    int sb_c[$];
    logic [7:0] sb_d[$];
    logic [7:0] es[$];
    logic [15:0] ea[$];
    logic v[16], w[16], r[16];
    logic [7:0] d[16];
    logic sw;
    logic [2:0] sw_t;
    logic [15:0] sw_a;
    string tname;
    int ec;
    logic [7:0] ed;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic clear();
        foreach (v[i]) begin
            v[i] = 1'b0;
            w[i] = 1'b0;
            r[i] = 1'b0;
            d[i] = 8'h00;
        end
        sw = 1'b0;
    endtask

    task automatic start(input logic [2:0] t, input logic [15:0] a, input logic [7:0] wd);
        req_valid = 1'b1;
        req_type  = t;
        req_addr  = a;
        req_wdata = wd;
    endtask

    task automatic expect_rsp(input int off, input logic [7:0] dat);
        sb_c.push_back(cyc + off);
        sb_d.push_back(dat);
    endtask

    task automatic run();
        for (int i = 0; i < es.size(); i++) begin
            @(negedge clk);
            check($sformatf("%s_strobes%0d", tname, i), 32'(sv), 32'(es[i]));
            check($sformatf("%s_addr%0d", tname, i), 32'(address_bus), 32'(ea[i]));
            req_valid = v[i];
            wait_in   = w[i];
            data_in   = d[i];
            reset     = r[i];
            if (i == 0 && sw) begin
                req_type = sw_t;
                req_addr = sw_a;
            end
        end
    endtask

    always @(negedge clk) begin
        if (rsp_valid === 1'b1) begin
            if (sb_c.size() == 0) begin
                total++;
                bad++;
                $display("FAIL rsp_unexpected: got rsp_valid at cycle %0d expected none", cyc);
            end else begin
                ec = sb_c.pop_front();
                ed = sb_d.pop_front();
                check("rsp_cycle", 32'(cyc), 32'(ec));
                check("rsp_rdata", 32'(rsp_rdata), 32'(ed));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clear();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_strobes", 32'(sv), 32'h80);
        check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        check("rst_rdata", 32'(rsp_rdata), 32'h0);
        check("rst_addr", 32'(address_bus), 32'h0);
        check("rst_data_out", 32'(data_out), 32'h0);
        reset = 1'b0;

        tname = "fetch";
        clear();
        d[1] = 8'h3E;
        es = '{8'h68, 8'h68, 8'h22, 8'hA2, 8'h80};
        ea = '{16'h1234, 16'h1234, 16'h0042, 16'h0042, 16'h0042};
        start(3'd0, 16'h1234, 8'h00);
        expect_rsp(3, 8'h3E);
        run();

        tname = "memwr";
        clear();
        w[1] = 1'b1;
        w[2] = 1'b1;
        es = '{8'h21, 8'h25, 8'h25, 8'h25, 8'hA5, 8'h80};
        ea = '{16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000};
        start(3'd2, 16'h8000, 8'hA5);
        expect_rsp(6, 8'h3E);
        run();
        check("memwr_data_out", 32'(data_out), 32'hA5);

        tname = "iord";
        clear();
        d[3] = 8'h7F;
        es = '{8'h00, 8'h18, 8'h18, 8'h98, 8'h80};
        ea = '{16'h00FE, 16'h00FE, 16'h00FE, 16'h00FE, 16'h00FE};
        start(3'd3, 16'h00FE, 8'h11);
        expect_rsp(5, 8'h7F);
        run();
        check("iord_data_out", 32'(data_out), 32'hA5);

        tname = "intack";
        clear();
        d[4] = 8'hFF;
        es = '{8'h40, 8'h40, 8'h40, 8'h50, 8'hD0, 8'h80};
        ea = '{16'h0038, 16'h0038, 16'h0038, 16'h0038, 16'h0038, 16'h0038};
        start(3'd5, 16'h0038, 8'h00);
        expect_rsp(6, 8'hFF);
        run();

        tname = "b2b";
        clear();
        v[0] = 1'b1;
        v[1] = 1'b1;
        v[2] = 1'b1;
        v[3] = 1'b1;
        d[1] = 8'hC3;
        d[6] = 8'h5A;
        sw   = 1'b1;
        sw_t = 3'd1;
        sw_a = 16'h2000;
        es = '{8'h68, 8'h68, 8'h22, 8'hA2, 8'h28, 8'h28, 8'hA8, 8'h80};
        ea = '{16'h0100, 16'h0100, 16'h0042, 16'h0042, 16'h2000, 16'h2000, 16'h2000, 16'h2000};
        start(3'd0, 16'h0100, 8'h00);
        expect_rsp(3, 8'hC3);
        expect_rsp(8, 8'h5A);
        run();

        tname = "reset";
        clear();
        w[1] = 1'b1;
        w[2] = 1'b1;
        r[2] = 1'b1;
        es = '{8'h28, 8'h28, 8'h28, 8'h80, 8'h80};
        ea = '{16'h3000, 16'h3000, 16'h3000, 16'h0000, 16'h0000};
        start(3'd1, 16'h3000, 8'h00);
        run();
        check("reset_data_out", 32'(data_out), 32'h0);
        check("reset_rdata", 32'(rsp_rdata), 32'h0);

        tname = "reserved";
        clear();
        es = '{8'h80, 8'h80, 8'h80};
        ea = '{16'h0000, 16'h0000, 16'h0000};
        start(3'd6, 16'h7777, 8'h99);
        run();
        check("reserved_data_out", 32'(data_out), 32'h0);

        repeat (4) @(negedge clk);
        check("sb_empty", 32'(sb_c.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
